tx_frame_shifter: RTL and testbench
===================================

TX_FRAME_SHIFTER -- requirements
Module: tx_frame_shifter

Interface
REQ-001 Parameter DATA_W, default 8, meaning maximum data bits per frame (legal range 5..16).
REQ-002 reset  input  1  asynchronous, active-high.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 baud_tick  input  1  one-clk strobe per bit time.
REQ-005 tx_valid  input  1  frame request.
REQ-006 tx_data  input  DATA_W  payload, LSB transmitted first.
REQ-007 data_len  input  5  data bit count.
REQ-008 parity_en  input  1  parity bit included when 1.
REQ-009 parity_odd  input  1  selects odd parity when 1, even when 0.
REQ-010 two_stop  input  1  selects two stop bits when 1, one when 0.
REQ-011 tx_ready  output  1  block can accept a frame.
REQ-012 txd  output  1  serial line, registered.
REQ-013 busy  output  1  frame in progress.
REQ-014 frame_done  output  1  one-clk pulse at end of frame.

Function
REQ-015 Frame accept SHALL occur on a rising edge with tx_valid=1 and tx_ready=1.
REQ-016 tx_ready SHALL equal 1 only in IDLE.
REQ-017 tx_valid while not IDLE SHALL be ignored and SHALL NOT be queued.
REQ-018 At accept, the block SHALL capture tx_data, effective length, parity_en, parity_odd and two_stop; later changes to these inputs SHALL NOT affect the frame in flight.
REQ-019 Effective length SHALL be data_len when 1 <= data_len <= DATA_W, and SHALL be DATA_W otherwise (including 0).
REQ-020 States: IDLE, ARM, START, DATA, PARITY, STOP1, STOP2.
REQ-021 IDLE: txd=1; on accept, next state ARM.
REQ-022 ARM: txd=1; on baud_tick, next state START, so every bit lasts a full tick interval.
REQ-023 START: txd=0; on baud_tick, next state DATA with bit index 0.
REQ-024 DATA: txd=captured bit[index]; on baud_tick, increment index.
REQ-025 DATA exit: after bit (effective length - 1), next state PARITY if parity_en, else STOP1.
REQ-026 PARITY: txd = XOR of the transmitted data bits only, inverted when parity_odd=1; on baud_tick, next state STOP1.
REQ-027 STOP1: txd=1; on baud_tick, next state STOP2 if two_stop, else IDLE.
REQ-028 STOP2: txd=1; on baud_tick, next state IDLE.
REQ-029 frame_done SHALL pulse high for exactly the clk following the baud_tick that ends the last stop bit, coincident with the return to IDLE and tx_ready=1.
REQ-030 A new accept MAY occur in that same cycle; back-to-back frames SHALL then re-enter ARM with txd=1 and no glitch.
REQ-031 busy SHALL be high in every state except IDLE.
REQ-032 State SHALL NOT advance without baud_tick; a tick arriving in the accept cycle SHALL be ignored.
REQ-033 Frame length in ticks SHALL be 1 (ARM) + 1 + N + P + S, where N is the effective length, P is parity_en and S is 1 or 2.

Reset
REQ-034 Reset asserted SHALL immediately force state=IDLE, txd=1, tx_ready=1, busy=0 and frame_done=0, and SHALL clear the index and captured registers.
REQ-035 Reset asserted mid-frame SHALL abort the frame with no frame_done pulse; txd SHALL return high asynchronously.
REQ-036 After reset deassertion, the first accept SHALL be possible on the next rising edge.

Verification
REQ-037 DATA_W=8, data_len=8, tx_data=0x55, no parity, one stop -> after ARM, txd sequence per tick is 0,1,0,1,0,1,0,1,0,1; frame_done pulses once; busy spans 11 ticks.
REQ-038 data_len=7, tx_data=0x41, parity_en=1, parity_odd=0 -> data bits 1,0,0,0,0,0,1 then parity 0, then stop 1; repeat with parity_odd=1 -> parity 1.
REQ-039 data_len=0 and data_len=20 with tx_data=0xA5 -> both transmit all 8 bits of 0xA5; two_stop=1 gives two high stop ticks before frame_done.
REQ-040 Toggle tx_data, data_len and parity_odd mid-frame, and hold tx_valid high throughout -> the frame in flight is unchanged, the second frame starts in the frame_done cycle, and no request is accepted while busy.
REQ-041 Assert reset during DATA bit 3 -> txd=1 and tx_ready=1 without waiting for clk; no frame_done pulse; a new frame completes normally afterwards.
REQ-042 Hold baud_tick=0 for 100 clk after accept -> state stays ARM with txd=1 and busy=1.

Source files
------------

// File: rtl/tx_frame_shifter.sv
// Asynchronous serial frame transmitter: start bit, 1..DATA_W data bits (LSB first),
// optional even/odd parity, one or two stop bits, paced by an external baud_tick strobe.
module tx_frame_shifter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              baud_tick,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [4:0]        data_len,
  input  logic              parity_en,
  input  logic              parity_odd,
  input  logic              two_stop,
  output logic              tx_ready,
  output logic              txd,
  output logic              busy,
  output logic              frame_done
);

  typedef enum logic [2:0] {
    IDLE, ARM, START, DATA, PARITY, STOP1, STOP2
  } state_t;

  localparam logic [4:0] LEN_MAX = 5'(DATA_W);

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [4:0]        remain;
  logic              par_en_q;
  logic              par_bit_q;
  logic              two_stop_q;

  logic [4:0]        eff_len;
  logic              data_par;

  // Parity covers only the bits that will actually be sent, so it is resolved at accept.
  always_comb begin
    eff_len  = (data_len == '0 || data_len > LEN_MAX) ? LEN_MAX : data_len;
    data_par = 1'b0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (i < 32'(eff_len)) data_par = data_par ^ tx_data[i];
    end
  end

  // txd/busy/tx_ready are registered alongside the state, each written with the value
  // belonging to the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      txd        <= 1'b1;
      tx_ready   <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      shreg      <= '0;
      remain     <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid) begin
            state      <= ARM;
            txd        <= 1'b1;
            tx_ready   <= 1'b0;
            busy       <= 1'b1;
            shreg      <= tx_data;
            remain     <= eff_len;
            par_en_q   <= parity_en;
            par_bit_q  <= data_par ^ parity_odd;
            two_stop_q <= two_stop;
          end
        end
        ARM: begin
          if (baud_tick) begin
            state <= START;
            txd   <= 1'b0;
          end
        end
        START: begin
          if (baud_tick) begin
            state <= DATA;
            txd   <= shreg[0];
          end
        end
        DATA: begin
          if (baud_tick) begin
            if (remain == 5'd1) begin
              if (par_en_q) begin
                state <= PARITY;
                txd   <= par_bit_q;
              end else begin
                state <= STOP1;
                txd   <= 1'b1;
              end
            end else begin
              remain <= remain - 5'd1;
              shreg  <= shreg >> 1;
              txd    <= shreg[1];
            end
          end
        end
        PARITY: begin
          if (baud_tick) begin
            state <= STOP1;
            txd   <= 1'b1;
          end
        end
        STOP1: begin
          if (baud_tick) begin
            txd <= 1'b1;
            if (two_stop_q) begin
              state <= STOP2;
            end else begin
              state      <= IDLE;
              busy       <= 1'b0;
              tx_ready   <= 1'b1;
              frame_done <= 1'b1;
            end
          end
        end
        STOP2: begin
          if (baud_tick) begin
            state      <= IDLE;
            txd        <= 1'b1;
            busy       <= 1'b0;
            tx_ready   <= 1'b1;
            frame_done <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          txd      <= 1'b1;
          busy     <= 1'b0;
          tx_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_frame_shifter.sv
// Scoreboard bench for tx_frame_shifter: expected line sequences (one char per tick,
// ARM first) are queued at issue; a negedge monitor records txd per tick and compares at frame_done.
module tb_tx_frame_shifter;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              baud_tick = 1'b0;
  logic              tx_valid = 1'b0;
  logic [DATA_W-1:0] tx_data = '0;
  logic [4:0]        data_len = '0;
  logic              parity_en = 1'b0;
  logic              parity_odd = 1'b0;
  logic              two_stop = 1'b0;
  logic              tx_ready, txd, busy, frame_done;

  int    n_tests = 0;
  int    n_fail  = 0;
  string exp_q[$];
  string rec = "";
  logic  prev_fd = 1'b0;
  logic  tick_en = 1'b1;
  int    tcnt = 0;

  tx_frame_shifter #(.DATA_W(DATA_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .baud_tick  (baud_tick),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .data_len   (data_len),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .two_stop   (two_stop),
    .tx_ready   (tx_ready),
    .txd        (txd),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // One tick every 4 clocks while enabled.
  always @(posedge clk) begin
    #1;
    if (tick_en) begin
      tcnt = (tcnt + 1) % 4;
      baud_tick = (tcnt == 0);
    end else begin
      baud_tick = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      rec = "";
      prev_fd = 1'b0;
    end else begin
      if (baud_tick && busy && rec.len() < 64) begin
        if (txd) rec = {rec, "1"};
        else     rec = {rec, "0"};
      end
      if (!busy) chk("idle_txd_high", txd, 1);
      chk("ready_eq_not_busy", tx_ready, !busy);
      if (frame_done) begin
        chk("done_single_cycle", prev_fd, 0);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_frame_done: got frame %s required none", rec);
        end else begin
          string e;
          e = exp_q.pop_front();
          n_tests++;
          if (rec != e) begin
            n_fail++;
            $display("FAIL frame_bits: got %s required %s", rec, e);
          end
        end
        rec = "";
      end
      prev_fd = frame_done;
    end
  end

  task automatic send(input logic [7:0] d, input logic [4:0] len, input logic pe,
                      input logic po, input logic ts, input bit align,
                      input string exp, input bit push);
    if (align) begin
      bit found = 1'b0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (baud_tick) begin
          found = 1'b1;
          break;
        end
      end
      if (!found) begin
        n_tests++;
        n_fail++;
        $display("FAIL align_timeout: got no tick required tick within 20 clk");
      end
    end
    tx_data    = d;
    data_len   = len;
    parity_en  = pe;
    parity_odd = po;
    two_stop   = ts;
    if (push) exp_q.push_back(exp);
    tx_valid = 1'b1;
    @(posedge clk);
    #2;
    chk("accept_busy", busy, 1);
    chk("accept_arm_txd", txd, 1);
    tx_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (frame_done) return;
    end
    n_tests++;
    n_fail++;
    $display("FAIL done_timeout: got no frame_done required one within %0d clk", budget);
  endtask

  initial begin
    int ticks;
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_txd", txd, 1);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    reset = 1'b0;

    send(8'h55, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, "10101010101", 1'b1);
    wait_done(200);
    send(8'h41, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, "10100000101", 1'b1);
    wait_done(200);
    send(8'h41, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, "10100000111", 1'b1);
    wait_done(200);
    send(8'hA5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, "10101001011", 1'b1);
    wait_done(200);
    send(8'hA5, 5'd20, 1'b0, 1'b0, 1'b1, 1'b0, "101010010111", 1'b1);
    wait_done(200);

    // Inputs change mid-frame with tx_valid held: the change becomes the next frame.
    tx_data = 8'h3C; data_len = 5'd6; parity_en = 1'b1; parity_odd = 1'b1; two_stop = 1'b0;
    exp_q.push_back("1000111111");
    tx_valid = 1'b1;
    @(posedge clk);
    #2;
    chk("hold_accept_a", busy, 1);
    repeat (12) @(posedge clk);
    #2;
    tx_data = 8'hC3; data_len = 5'd8; parity_odd = 1'b0;
    exp_q.push_back("101100001101");
    wait_done(200);
    @(posedge clk);
    #2;
    chk("b2b_start_busy", busy, 1);
    chk("b2b_start_txd", txd, 1);
    tx_valid = 1'b0;
    wait_done(200);
    repeat (3) @(posedge clk);
    #2;
    chk("idle_after_b2b", busy, 0);

    // Abort during data bit 3 (bit 3 of 0x55 is 0).
    send(8'h55, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, "", 1'b0);
    ticks = 0;
    for (int c = 0; c < 200 && ticks < 5; c++) begin
      @(negedge clk);
      if (baud_tick && busy) ticks++;
    end
    chk("abort_reach_bit3", ticks, 5);
    @(posedge clk);
    #2;
    chk("data_bit3_low", txd, 0);
    reset = 1'b1;
    #1;
    chk("abort_txd", txd, 1);
    chk("abort_ready", tx_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", frame_done, 0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    send(8'h96, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, "100110100111", 1'b1);
    wait_done(200);

    // No ticks for 100 clk after accept: must sit in ARM.
    tick_en = 1'b0;
    send(8'h0F, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, "1011110011", 1'b1);
    repeat (100) @(posedge clk);
    #2;
    chk("stall_txd", txd, 1);
    chk("stall_busy", busy, 1);
    chk("stall_ready", tx_ready, 0);
    tick_en = 1'b1;
    wait_done(200);

    repeat (20) @(posedge clk);
    #2;
    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
